// File: rtl/sfs_pkg.sv
// Shared types and helpers for the systolic feed scheduler.
//   sfs_state_e : scheduler FSM encoding (IDLE, LOAD, DRAIN, DONE)
//   sfs_cnt_w() : counter width derived from ROWS and KLEN
package sfs_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } sfs_state_e;

  // Enough bits to hold KLEN+ROWS-1, plus one guard bit (32/32 gives 7).
  function automatic int sfs_cnt_w(input int rows, input int klen);
    return $clog2(klen + rows) + 1;
  endfunction

endpackage

// File: rtl/sfs_row_window.sv
// Pop window for a single row FIFO.
// Row r is popped on drain steps r .. r+KLEN-1, which staggers the rows
// into a diagonal wavefront at the PE array edge.
// Ports:
//   d_i    : current drain step count
//   row_i  : row index of this window
//   step_i : drain advances this cycle (not stalled)
//   pop_o  : pop enable for this row
module sfs_row_window
  import sfs_pkg::*;
#(
  parameter int CNT_W     = 7,
  parameter int ROWS_LOG2 = 5,
  parameter int KLEN      = 32
) (
  input  logic [CNT_W-1:0]     d_i,
  input  logic [ROWS_LOG2-1:0] row_i,
  input  logic                 step_i,
  output logic                 pop_o
);

  logic [CNT_W-1:0] lo;
  logic [CNT_W-1:0] hi;

  // Zero-extend the row index so both bounds compare unsigned at CNT_W bits.
  assign lo    = CNT_W'(row_i);
  assign hi    = lo + CNT_W'(KLEN);
  assign pop_o = step_i & (d_i >= lo) & (d_i < hi);

endmodule

// File: rtl/systolic_feed_scheduler.sv
// Control sequencer for the per-row operand FIFOs feeding the systolic array.
// LOAD pushes one column beat into every row FIFO per accepted host beat;
// DRAIN pops the rows with an i-cycle diagonal skew. Data buses are external.
// Ports:
//   CLK, RSTn            : clock, asynchronous active-low reset
//   START                : tile start pulse, honoured only in IDLE
//   LD_VALID / LD_READY  : host beat handshake (push on both high)
//   PE_STALL             : array back-pressure, freezes the drain
//   FIFO_FULL/FIFO_EMPTY : per-row FIFO status
//   PUSH_EN / POP_EN     : per-row FIFO enables (POP_EN doubles as row valid)
//   BUSY, DONE           : not idle / one-cycle tile-complete pulse
//   UNDERFLOW            : sticky, a pop hit an empty FIFO
module systolic_feed_scheduler
  import sfs_pkg::*;
#(
  parameter int ROWS      = 32,
  parameter int ROWS_LOG2 = 5,
  parameter int KLEN      = 32,
  parameter int CNT_W     = sfs_cnt_w(ROWS, KLEN)
) (
  input  logic            CLK,
  input  logic            RSTn,
  input  logic            START,
  input  logic            LD_VALID,
  output logic            LD_READY,
  input  logic            PE_STALL,
  input  logic [ROWS-1:0] FIFO_FULL,
  input  logic [ROWS-1:0] FIFO_EMPTY,
  output logic [ROWS-1:0] PUSH_EN,
  output logic [ROWS-1:0] POP_EN,
  output logic            BUSY,
  output logic            DONE,
  output logic            UNDERFLOW
);

  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);
  localparam logic [CNT_W-1:0] KLEN_M1 = CNT_W'(KLEN - 1);
  localparam logic [CNT_W-1:0] D_LAST  = CNT_W'(KLEN + ROWS - 2);

  sfs_state_e       state_q, state_d;
  logic [CNT_W-1:0] load_cnt_q, load_cnt_d;
  logic [CNT_W-1:0] drain_cnt_q, drain_cnt_d;
  logic             underflow_q, underflow_d;
  logic             step;

  // Enables are decoded from the state register so an asynchronous reset
  // drops them in the same cycle.
  assign LD_READY  = (state_q == S_LOAD) & ~|FIFO_FULL;
  assign PUSH_EN   = {ROWS{LD_VALID & LD_READY}};
  assign step      = (state_q == S_DRAIN) & ~PE_STALL;
  assign BUSY      = (state_q != S_IDLE);
  assign DONE      = (state_q == S_DONE);
  assign UNDERFLOW = underflow_q;

  for (genvar r = 0; r < ROWS; r++) begin : g_row
    sfs_row_window #(
      .CNT_W     (CNT_W),
      .ROWS_LOG2 (ROWS_LOG2),
      .KLEN      (KLEN)
    ) u_win (
      .d_i    (drain_cnt_q),
      .row_i  (ROWS_LOG2'(r)),
      .step_i (step),
      .pop_o  (POP_EN[r])
    );
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state_q     <= S_IDLE;
      load_cnt_q  <= '0;
      drain_cnt_q <= '0;
      underflow_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      load_cnt_q  <= load_cnt_d;
      drain_cnt_q <= drain_cnt_d;
      underflow_q <= underflow_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    load_cnt_d  = load_cnt_q;
    drain_cnt_d = drain_cnt_q;
    // The offending pop is still issued; only the flag records it.
    underflow_d = underflow_q | |(POP_EN & FIFO_EMPTY);
    case (state_q)
      S_IDLE: begin
        if (START) begin
          state_d     = S_LOAD;
          load_cnt_d  = '0;
          drain_cnt_d = '0;
          underflow_d = 1'b0;
        end
      end
      S_LOAD: begin
        if (LD_VALID && LD_READY) begin
          load_cnt_d = load_cnt_q + ONE;
          if (load_cnt_q == KLEN_M1) state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (step) begin
          drain_cnt_d = drain_cnt_q + ONE;
          if (drain_cnt_q == D_LAST) state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_systolic_feed_scheduler.sv
module tb_systolic_feed_scheduler;

  localparam int BIG_ROWS = 32;
  localparam int BIG_KLEN = 32;

  logic       CLK;
  logic       RSTn;
  logic       START, LD_VALID, PE_STALL;
  logic [3:0] FIFO_FULL, FIFO_EMPTY;
  logic       LD_READY, BUSY, DONE, UNDERFLOW;
  logic [3:0] PUSH_EN, POP_EN;

  logic                big_start, big_ldv;
  logic                big_ready, big_busy, big_done, big_unf;
  logic [BIG_ROWS-1:0] big_full, big_empty, big_push, big_pop;

  systolic_feed_scheduler #(.ROWS(4), .ROWS_LOG2(2), .KLEN(3)) dut (
    .CLK(CLK), .RSTn(RSTn), .START(START), .LD_VALID(LD_VALID),
    .LD_READY(LD_READY), .PE_STALL(PE_STALL), .FIFO_FULL(FIFO_FULL),
    .FIFO_EMPTY(FIFO_EMPTY), .PUSH_EN(PUSH_EN), .POP_EN(POP_EN),
    .BUSY(BUSY), .DONE(DONE), .UNDERFLOW(UNDERFLOW)
  );

  systolic_feed_scheduler big (
    .CLK(CLK), .RSTn(RSTn), .START(big_start), .LD_VALID(big_ldv),
    .LD_READY(big_ready), .PE_STALL(1'b0), .FIFO_FULL(big_full),
    .FIFO_EMPTY(big_empty), .PUSH_EN(big_push), .POP_EN(big_pop),
    .BUSY(big_busy), .DONE(big_done), .UNDERFLOW(big_unf)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int          n_vec = 0;
  int          n_bad = 0;
  string       tag_q[$];
  logic [11:0] exp_q[$];

  bit smoke_go  = 1'b0;
  bit smoke_end = 1'b0;
  int sm_cyc = 0, sm_push = 0, sm_drain = 0;
  int sm_pop[BIG_ROWS];

  // Drive one cycle of inputs and queue the outputs expected during it.
  // Expected order: rdy, push, pop, busy, done, unf.
  task automatic v(input string t, input logic rn, st, lv, sl,
                   input logic [3:0] fu, em,
                   input logic rdy, input logic [3:0] pu, po,
                   input logic bz, dn, uf);
    @(posedge CLK);
    #1;
    RSTn = rn; START = st; LD_VALID = lv; PE_STALL = sl;
    FIFO_FULL = fu; FIFO_EMPTY = em;
    tag_q.push_back(t);
    exp_q.push_back({rdy, pu, po, bz, dn, uf});
  endtask

  // Monitor: pops one expectation per cycle and compares mid-cycle.
  initial begin : monitor
    logic [11:0] got, want;
    string       t;
    bit          ok;
    forever begin
      @(negedge CLK);
      if (exp_q.size() > 0) begin
        want = exp_q.pop_front();
        t    = tag_q.pop_front();
        got  = {LD_READY, PUSH_EN, POP_EN, BUSY, DONE, UNDERFLOW};
        n_vec++;
        if (got !== want) begin
          n_bad++;
          $display("FAIL %s: got rdy=%b push=%b pop=%b busy=%b done=%b unf=%b, want rdy=%b push=%b pop=%b busy=%b done=%b unf=%b",
                   t, got[11], got[10:7], got[6:3], got[2], got[1], got[0],
                   want[11], want[10:7], want[6:3], want[2], want[1], want[0]);
        end
      end
      if (smoke_go && !smoke_end) begin
        sm_cyc++;
        if (&big_push) sm_push++;
        if (|big_pop) sm_drain++;
        for (int r = 0; r < BIG_ROWS; r++) if (big_pop[r]) sm_pop[r]++;
        if (big_done) begin
          n_vec++;
          if (sm_push != BIG_KLEN) begin
            n_bad++;
            $display("FAIL smoke_push_beats: got %0d, want %0d", sm_push, BIG_KLEN);
          end
          n_vec++;
          if (sm_drain != BIG_KLEN + BIG_ROWS - 1) begin
            n_bad++;
            $display("FAIL smoke_drain_cycles: got %0d, want %0d", sm_drain, BIG_KLEN + BIG_ROWS - 1);
          end
          ok = 1'b1;
          for (int r = 0; r < BIG_ROWS; r++) if (sm_pop[r] != BIG_KLEN) ok = 1'b0;
          n_vec++;
          if (!ok) begin
            n_bad++;
            $display("FAIL smoke_row_pops: row0=%0d row31=%0d, want %0d each", sm_pop[0], sm_pop[31], BIG_KLEN);
          end
          smoke_end = 1'b1;
        end else if (sm_cyc > 300) begin
          n_vec++;
          n_bad++;
          $display("FAIL smoke_timeout: got no DONE in %0d cycles, want DONE", sm_cyc);
          smoke_end = 1'b1;
        end
      end
    end
  end

  initial begin : stimulus
    RSTn = 1'b0; START = 1'b0; LD_VALID = 1'b0; PE_STALL = 1'b0;
    FIFO_FULL = '0; FIFO_EMPTY = '0;
    big_start = 1'b0; big_ldv = 1'b0; big_full = '0; big_empty = '0;

    // Reset held with random inputs: everything quiet.
    repeat (3) v("reset", 0, 1'($urandom), 1'($urandom), 1'($urandom),
                 4'($urandom), 4'($urandom), 0, 4'h0, 4'h0, 0, 0, 0);
    v("idle", 1, 0, 0, 0, 0, 0, 0, 4'h0, 4'h0, 0, 0, 0);

    // Plain tile.
    v("t1_start", 1, 1, 0, 0, 0, 0, 0, 4'h0, 4'h0, 0, 0, 0);
    v("t1_ld0",   1, 0, 1, 0, 0, 0, 1, 4'hF, 4'h0, 1, 0, 0);
    v("t1_ld1",   1, 0, 1, 0, 0, 0, 1, 4'hF, 4'h0, 1, 0, 0);
    v("t1_ld2",   1, 0, 1, 0, 0, 0, 1, 4'hF, 4'h0, 1, 0, 0);
    v("t1_d0",    1, 0, 1, 0, 0, 0, 0, 4'h0, 4'b0001, 1, 0, 0);
    v("t1_d1",    1, 0, 0, 0, 0, 0, 0, 4'h0, 4'b0011, 1, 0, 0);
    v("t1_d2",    1, 0, 0, 0, 0, 0, 0, 4'h0, 4'b0111, 1, 0, 0);
    v("t1_d3",    1, 0, 0, 0, 0, 0, 0, 4'h0, 4'b1110, 1, 0, 0);
    v("t1_d4",    1, 0, 0, 0, 0, 0, 0, 4'h0, 4'b1100, 1, 0, 0);
    v("t1_d5",    1, 0, 0, 0, 0, 0, 0, 4'h0, 4'b1000, 1, 0, 0);
    v("t1_done",  1, 1, 0, 0, 0, 0, 0, 4'h0, 4'h0, 1, 1, 0);
    v("t1_idle",  1, 0, 0, 0, 0, 0, 0, 4'h0, 4'h0, 0, 0, 0);

    // Stall ignored in LOAD, freezes DRAIN for two cycles.
    v("t2_start", 1, 1, 0, 0, 0, 0, 0, 4'h0, 4'h0, 0, 0, 0);
    v("t2_ld0",   1, 0, 1, 1, 0, 0, 1, 4'hF, 4'h0, 1, 0, 0);
    v("t2_ld1",   1, 0, 1, 0, 0, 0, 1, 4'hF, 4'h0, 1, 0, 0);
    v("t2_ld2",   1, 0, 1, 1, 0, 0, 1, 4'hF, 4'h0, 1, 0, 0);
    v("t2_d0",    1, 0, 0, 0, 0, 0, 0, 4'h0, 4'b0001, 1, 0, 0);
    v("t2_d1",    1, 0, 0, 0, 0, 0, 0, 4'h0, 4'b0011, 1, 0, 0);
    v("t2_st0",   1, 0, 0, 1, 0, 0, 0, 4'h0, 4'h0, 1, 0, 0);
    v("t2_st1",   1, 1, 0, 1, 0, 0, 0, 4'h0, 4'h0, 1, 0, 0);
    v("t2_d2",    1, 0, 0, 0, 0, 0, 0, 4'h0, 4'b0111, 1, 0, 0);
    v("t2_d3",    1, 0, 0, 0, 0, 0, 0, 4'h0, 4'b1110, 1, 0, 0);
    v("t2_d4",    1, 0, 0, 0, 0, 0, 0, 4'h0, 4'b1100, 1, 0, 0);
    v("t2_d5",    1, 0, 0, 0, 0, 0, 0, 4'h0, 4'b1000, 1, 0, 0);
    v("t2_done",  1, 0, 0, 0, 0, 0, 0, 4'h0, 4'h0, 1, 1, 0);
    v("t2_idle",  1, 0, 0, 0, 0, 0, 0, 4'h0, 4'h0, 0, 0, 0);

    // A full FIFO blocks the beat and holds the load count.
    v("t3_start", 1, 1, 0, 0, 0, 0, 0, 4'h0, 4'h0, 0, 0, 0);
    v("t3_ld0",   1, 0, 1, 0, 0, 0, 1, 4'hF, 4'h0, 1, 0, 0);
    v("t3_full0", 1, 0, 1, 0, 4'b0100, 0, 0, 4'h0, 4'h0, 1, 0, 0);
    v("t3_full1", 1, 0, 1, 0, 4'b0100, 0, 0, 4'h0, 4'h0, 1, 0, 0);
    v("t3_ld1",   1, 0, 1, 0, 0, 0, 1, 4'hF, 4'h0, 1, 0, 0);
    v("t3_noval", 1, 0, 0, 0, 0, 0, 1, 4'h0, 4'h0, 1, 0, 0);
    v("t3_ld2",   1, 0, 1, 0, 0, 0, 1, 4'hF, 4'h0, 1, 0, 0);
    v("t3_d0",    1, 0, 0, 0, 0, 0, 0, 4'h0, 4'b0001, 1, 0, 0);
    v("t3_d1",    1, 0, 0, 0, 0, 0, 0, 4'h0, 4'b0011, 1, 0, 0);
    v("t3_d2",    1, 0, 0, 0, 0, 0, 0, 4'h0, 4'b0111, 1, 0, 0);
    v("t3_d3",    1, 0, 0, 0, 0, 0, 0, 4'h0, 4'b1110, 1, 0, 0);
    v("t3_d4",    1, 0, 0, 0, 0, 0, 0, 4'h0, 4'b1100, 1, 0, 0);
    v("t3_d5",    1, 0, 0, 0, 0, 0, 0, 4'h0, 4'b1000, 1, 0, 0);
    v("t3_done",  1, 0, 0, 0, 0, 0, 0, 4'h0, 4'h0, 1, 1, 0);
    v("t3_idle",  1, 0, 0, 0, 0, 0, 0, 4'h0, 4'h0, 0, 0, 0);

    // Underflow on the first pop: sticky through DONE and IDLE.
    v("t4_start", 1, 1, 0, 0, 0, 0, 0, 4'h0, 4'h0, 0, 0, 0);
    v("t4_ld0",   1, 0, 1, 0, 0, 0, 1, 4'hF, 4'h0, 1, 0, 0);
    v("t4_ld1",   1, 0, 1, 0, 0, 0, 1, 4'hF, 4'h0, 1, 0, 0);
    v("t4_ld2",   1, 0, 1, 0, 0, 0, 1, 4'hF, 4'h0, 1, 0, 0);
    v("t4_d0",    1, 0, 0, 0, 0, 4'b0001, 0, 4'h0, 4'b0001, 1, 0, 0);
    v("t4_d1",    1, 0, 0, 0, 0, 0, 0, 4'h0, 4'b0011, 1, 0, 1);
    v("t4_d2",    1, 0, 0, 0, 0, 0, 0, 4'h0, 4'b0111, 1, 0, 1);
    v("t4_d3",    1, 0, 0, 0, 0, 0, 0, 4'h0, 4'b1110, 1, 0, 1);
    v("t4_d4",    1, 0, 0, 0, 0, 0, 0, 4'h0, 4'b1100, 1, 0, 1);
    v("t4_d5",    1, 0, 0, 0, 0, 0, 0, 4'h0, 4'b1000, 1, 0, 1);
    v("t4_done",  1, 0, 0, 0, 0, 0, 0, 4'h0, 4'h0, 1, 1, 1);
    v("t4_idle",  1, 0, 0, 0, 0, 0, 0, 4'h0, 4'h0, 0, 0, 1);

    // Next START clears the flag; then async reset in the middle of drain.
    v("t5_start", 1, 1, 0, 0, 0, 0, 0, 4'h0, 4'h0, 0, 0, 1);
    v("t5_ld0",   1, 0, 1, 0, 0, 0, 1, 4'hF, 4'h0, 1, 0, 0);
    v("t5_ld1",   1, 0, 1, 0, 0, 0, 1, 4'hF, 4'h0, 1, 0, 0);
    v("t5_ld2",   1, 0, 1, 0, 0, 0, 1, 4'hF, 4'h0, 1, 0, 0);
    v("t5_d0",    1, 0, 0, 0, 0, 0, 0, 4'h0, 4'b0001, 1, 0, 0);
    v("t5_d1",    1, 0, 0, 0, 0, 4'b0011, 0, 4'h0, 4'b0011, 1, 0, 0);
    v("t5_d2",    1, 0, 0, 0, 0, 0, 0, 4'h0, 4'b0111, 1, 0, 1);
    v("t5_rst",   0, 0, 0, 0, 0, 0, 0, 4'h0, 4'h0, 0, 0, 0);
    v("t5_post",  1, 0, 0, 0, 0, 0, 0, 4'h0, 4'h0, 0, 0, 0);
    v("t5_rest",  1, 1, 0, 0, 0, 0, 0, 4'h0, 4'h0, 0, 0, 0);
    v("t5_reld",  1, 0, 1, 0, 0, 0, 1, 4'hF, 4'h0, 1, 0, 0);
    v("t5_rst2",  0, 0, 0, 0, 0, 0, 0, 4'h0, 4'h0, 0, 0, 0);
    v("t5_quiet", 1, 0, 0, 0, 0, 0, 0, 4'h0, 4'h0, 0, 0, 0);

    // Default-size smoke tile on the second instance.
    @(posedge CLK);
    #1;
    big_start = 1'b1;
    smoke_go  = 1'b1;
    @(posedge CLK);
    #1;
    big_start = 1'b0;
    big_ldv   = 1'b1;
    for (int i = 0; i < 400 && !smoke_end; i++) @(posedge CLK);
    big_ldv = 1'b0;

    repeat (2) @(negedge CLK);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
